// File: rtl/l3_refill_ctrl.sv
// l3_refill_ctrl: L3 miss refill controller (miss queue, burst read, line assembly, fill, free); define L3_REFILL_ERR_CNT_EN to add err_cnt
module l3_refill_ctrl #(
  parameter int NUM_MSHR   = 32,
  parameter int ID_WIDTH   = 10,
  parameter int ADDR_WIDTH = 32,
  parameter int LINE_BYTES = 64,
  parameter int DATA_WIDTH = 256,
  parameter int QDEPTH     = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          miss_valid,
  output logic                          miss_ready,
  input  logic [ADDR_WIDTH-1:0]         miss_addr,
  input  logic [ID_WIDTH-1:0]           miss_id,
  output logic                          ar_valid,
  input  logic                          ar_ready,
  output logic [ADDR_WIDTH-1:0]         ar_addr,
  output logic [ID_WIDTH-1:0]           ar_id,
  output logic [7:0]                    ar_len,
  input  logic                          r_valid,
  output logic                          r_ready,
  input  logic [DATA_WIDTH-1:0]         r_data,
  input  logic [ID_WIDTH-1:0]           r_id,
  input  logic                          r_last,
  input  logic [1:0]                    r_resp,
  output logic                          fill_valid,
  input  logic                          fill_ready,
  output logic [ADDR_WIDTH-1:0]         fill_addr,
  output logic [LINE_BYTES*8-1:0]       fill_data,
  output logic [ID_WIDTH-1:0]           fill_id,
  output logic                          fill_err,
  output logic                          free,
  output logic [ID_WIDTH-1:0]           free_id,
  output logic [$clog2(NUM_MSHR+1)-1:0] outstanding
`ifdef L3_REFILL_ERR_CNT_EN
  ,
  output logic [15:0]                   err_cnt
`endif
);
  localparam int BEATS = LINE_BYTES * 8 / DATA_WIDTH;
  localparam int LW = LINE_BYTES * 8;
  localparam int IW = $clog2(NUM_MSHR);
  localparam int QW = $clog2(QDEPTH);
  localparam int CW = $clog2(NUM_MSHR + 1);
  localparam int BW = $clog2(BEATS + 1);
  localparam logic [0:0] RX = 1'b0;
  localparam logic [0:0] FILL = 1'b1;

  logic [ADDR_WIDTH-1:0] q_addr [QDEPTH];
  logic [ID_WIDTH-1:0] q_id [QDEPTH];
  logic [ADDR_WIDTH-1:0] addr_tab [NUM_MSHR];
  logic [QW:0] wr_ptr, rd_ptr;
  logic empty, full, miss_hs, ar_hs, fill_hs, in_range, beat_err;
  logic [0:0] state;
  logic [BW-1:0] beat_cnt;
  logic [ID_WIDTH-1:0] cur_id;
  logic err;
  logic [LW-1:0] line;

  assign empty = wr_ptr == rd_ptr;
  assign full = (wr_ptr ^ rd_ptr) == {1'b1, {QW{1'b0}}};
  assign miss_ready = !full;
  assign miss_hs = miss_valid && !full;
  assign ar_valid = !empty && outstanding < CW'(NUM_MSHR);
  assign ar_hs = ar_valid && ar_ready;
  assign ar_addr = ar_valid ? q_addr[rd_ptr[QW-1:0]] : '0;
  assign ar_id = ar_valid ? q_id[rd_ptr[QW-1:0]] : '0;
  assign ar_len = ar_valid ? 8'(BEATS - 1) : 8'd0;

  assign r_ready = state == RX && !rst;
  assign in_range = beat_cnt < BW'(BEATS);
  assign beat_err = r_resp != 2'b00 || (r_last && beat_cnt != BW'(BEATS - 1)) ||
                    (beat_cnt != '0 && r_id != cur_id) || (!in_range && !r_last);

  assign fill_valid = state == FILL;
  assign fill_hs = fill_valid && fill_ready;
  assign fill_addr = fill_valid ? addr_tab[cur_id[IW-1:0]] : '0;
  assign fill_data = fill_valid ? line : '0;
  assign fill_id = fill_valid ? cur_id : '0;
  assign fill_err = fill_valid && err;

  // queue and address-table storage; validity comes from the pointers, so no reset needed
  always_ff @(posedge clk) begin
    if (miss_hs) begin
      q_addr[wr_ptr[QW-1:0]] <= miss_addr & ~ADDR_WIDTH'(LINE_BYTES - 1);
      q_id[wr_ptr[QW-1:0]] <= miss_id;
    end
    if (ar_hs) addr_tab[ar_id[IW-1:0]] <= ar_addr;
  end

  // queue pointers and count of reads issued but not yet filled
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      outstanding <= '0;
    end else begin
      wr_ptr <= wr_ptr + {{QW{1'b0}}, miss_hs};
      rd_ptr <= rd_ptr + {{QW{1'b0}}, ar_hs};
      outstanding <= outstanding + CW'(ar_hs) - CW'(fill_hs);
    end
  end

  // beat collection into the line buffer, then hold the line until the fill is taken
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= RX;
      beat_cnt <= '0;
      cur_id <= '0;
      err <= 1'b0;
      line <= '0;
    end else if (state == RX) begin
      if (r_valid) begin
        if (beat_cnt == '0) cur_id <= r_id;
        if (in_range) line[beat_cnt*DATA_WIDTH +: DATA_WIDTH] <= r_data;
        err <= err | beat_err;
        state <= r_last ? FILL : RX;
        beat_cnt <= r_last ? '0 : in_range ? beat_cnt + 1'b1 : beat_cnt;
      end
    end else if (fill_ready) begin
      state <= RX;
      err <= 1'b0;
    end
  end

  // one-cycle retire pulse after each accepted fill
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      free <= 1'b0;
      free_id <= '0;
    end else begin
      free <= fill_hs;
      free_id <= fill_hs ? fill_id : '0;
    end
  end

`ifdef L3_REFILL_ERR_CNT_EN
  // saturating count of poisoned lines handed to the arrays
  always_ff @(posedge clk or posedge rst) begin
    if (rst) err_cnt <= '0;
    else if (fill_hs && err && err_cnt != 16'hFFFF) err_cnt <= err_cnt + 16'd1;
  end
`endif
endmodule

// File: tb/tb_l3_refill_ctrl.sv
// tb_l3_refill_ctrl: bench for l3_refill_ctrl
module tb_l3_refill_ctrl;
  localparam int BEATS = 2;

  logic clk = 1'b0, rst = 1'b1;
  logic miss_valid = 0, miss_ready;
  logic [31:0] miss_addr = '0;
  logic [9:0] miss_id = '0;
  logic ar_valid, ar_ready = 0;
  logic [31:0] ar_addr;
  logic [9:0] ar_id;
  logic [7:0] ar_len;
  logic r_valid = 0, r_ready;
  logic [255:0] r_data = '0;
  logic [9:0] r_id = '0;
  logic r_last = 0;
  logic [1:0] r_resp = '0;
  logic fill_valid, fill_ready = 0;
  logic [31:0] fill_addr;
  logic [511:0] fill_data;
  logic [9:0] fill_id;
  logic fill_err, free;
  logic [9:0] free_id;
  logic [5:0] outstanding;
`ifdef L3_REFILL_ERR_CNT_EN
  logic [15:0] err_cnt;
`endif

  always #5 clk = ~clk;

  l3_refill_ctrl dut (
    .clk(clk), .rst(rst),
    .miss_valid(miss_valid), .miss_ready(miss_ready), .miss_addr(miss_addr), .miss_id(miss_id),
    .ar_valid(ar_valid), .ar_ready(ar_ready), .ar_addr(ar_addr), .ar_id(ar_id), .ar_len(ar_len),
    .r_valid(r_valid), .r_ready(r_ready), .r_data(r_data), .r_id(r_id), .r_last(r_last), .r_resp(r_resp),
    .fill_valid(fill_valid), .fill_ready(fill_ready), .fill_addr(fill_addr), .fill_data(fill_data),
    .fill_id(fill_id), .fill_err(fill_err), .free(free), .free_id(free_id), .outstanding(outstanding)
`ifdef L3_REFILL_ERR_CNT_EN
    , .err_cnt(err_cnt)
`endif
  );

  typedef struct {
    logic [31:0] addr;
    logic [9:0] id;
  } miss_t;

  miss_t mq[$];
  logic [9:0] iss_q[$];
  logic [31:0] m_tab [32];
  logic [255:0] m_line [BEATS];
  logic [9:0] m_cur = '0, m_free_id = '0;
  bit m_fill = 0, m_err = 0, m_free = 0, m_r_acc = 0;
  int m_out = 0, m_beat = 0, m_errcnt = 0;
  int n_cmp = 0, n_bad = 0;

  logic [255:0] da = {8{32'hAAAA_0001}};
  logic [255:0] db = {8{32'hBBBB_0002}};
  logic [255:0] b_data [4];
  logic [9:0] b_id [4];
  logic [1:0] b_resp [4];
  bit b_last [4];
  int b_n = 0, b_i = 0;

  task automatic chk(input string nm, input logic [511:0] got, input logic [511:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h at %0t", nm, got, exp, $time);
    end
  endtask

  // reference model: queue / table / line array advanced on each rising edge
  always @(posedge clk) begin
    bit ar_hs, fill_hs, miss_hs, r_hs;
    if (rst) begin
      mq.delete();
      iss_q.delete();
      m_out = 0; m_fill = 0; m_err = 0; m_free = 0; m_free_id = '0;
      m_r_acc = 0; m_beat = 0; m_cur = '0; m_errcnt = 0;
      foreach (m_line[i]) m_line[i] = '0;
    end else begin
      ar_hs = mq.size() > 0 && m_out < 32 && ar_ready;
      fill_hs = m_fill && fill_ready;
      miss_hs = miss_valid && mq.size() < 8;
      r_hs = !m_fill && r_valid;
      m_r_acc = r_hs;
      m_free = fill_hs;
      m_free_id = fill_hs ? m_cur : '0;
      if (ar_hs) begin
        m_tab[mq[0].id[4:0]] = mq[0].addr;
        iss_q.push_back(mq[0].id);
        void'(mq.pop_front());
        m_out++;
      end
      if (miss_hs) mq.push_back('{miss_addr & 32'hFFFF_FFC0, miss_id});
      if (fill_hs) begin
        m_out--;
        if (m_err && m_errcnt < 65535) m_errcnt++;
        m_fill = 0;
        m_err = 0;
      end
      if (r_hs) begin
        if (m_beat == 0) m_cur = r_id;
        else if (r_id != m_cur) m_err = 1;
        if (r_resp != 2'd0) m_err = 1;
        if (r_last && m_beat != BEATS - 1) m_err = 1;
        if (m_beat >= BEATS && !r_last) m_err = 1;
        if (m_beat < BEATS) m_line[m_beat] = r_data;
        if (r_last) begin
          m_fill = 1;
          m_beat = 0;
        end else if (m_beat < BEATS) m_beat++;
      end
    end
  end

  // every-cycle comparison of DUT outputs against the model
  always @(negedge clk) begin
    logic exp_arv;
    exp_arv = mq.size() > 0 && m_out < 32;
    chk("miss_ready", miss_ready, mq.size() < 8);
    chk("ar_valid", ar_valid, exp_arv);
    if (exp_arv) begin
      chk("ar_addr", ar_addr, mq[0].addr);
      chk("ar_id", ar_id, mq[0].id);
      chk("ar_len", ar_len, 1);
    end
    chk("outstanding", outstanding, m_out);
    chk("r_ready", r_ready, !m_fill && !rst);
    chk("fill_valid", fill_valid, m_fill);
    if (m_fill) begin
      chk("fill_addr", fill_addr, m_tab[m_cur[4:0]]);
      chk("fill_id", fill_id, m_cur);
      chk("fill_err", fill_err, m_err);
      chk("fill_data", fill_data, {m_line[1], m_line[0]});
    end
    chk("free", free, m_free);
    if (m_free) chk("free_id", free_id, m_free_id);
`ifdef L3_REFILL_ERR_CNT_EN
    chk("err_cnt", err_cnt, m_errcnt);
`endif
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic send_beat(input logic [255:0] d, input logic [9:0] id, input bit last, input logic [1:0] resp);
    r_valid = 1; r_data = d; r_id = id; r_last = last; r_resp = resp;
    tick(1);
    r_valid = 0; r_last = 0; r_resp = '0;
  endtask

  task automatic mk_burst(input logic [9:0] id, input int mode);
    b_n = mode == 7 ? 1 : mode == 9 ? 4 : 2;
    b_i = 0;
    for (int i = 0; i < 4; i++) begin
      for (int w = 0; w < 8; w++) b_data[i][w*32 +: 32] = $urandom;
      b_id[i] = id;
      b_resp[i] = '0;
      b_last[i] = i == b_n - 1;
    end
    if (mode == 6) b_resp[$urandom_range(0, 1)] = 2'($urandom_range(1, 3));
    if (mode == 8) b_id[1] = id ^ 10'h200;
  endtask

  task automatic ret(input int mode);
    mk_burst(iss_q.pop_front(), mode);
    b_data[0] = da;
    b_data[1] = db;
    if (mode == 6) begin
      b_resp[0] = 2'd2;
      b_resp[1] = 2'd0;
    end
    for (int i = 0; i < b_n; i++) send_beat(b_data[i], b_id[i], b_last[i], b_resp[i]);
    b_i = b_n;
  endtask

  task automatic release_fill;
    fill_ready = 1;
    tick(1);
    fill_ready = 0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    tick(3);
    chk("rst_outstanding", outstanding, 0);
    chk("rst_miss_ready", miss_ready, 1);
    chk("rst_r_ready", r_ready, 0);
    chk("rst_ar_valid", ar_valid, 0);
    chk("rst_fill_valid", fill_valid, 0);
    chk("rst_free", free, 0);
    rst = 0;
    tick(1);

    miss_valid = 1; miss_addr = 32'h0000_1234; miss_id = 10'd5;
    tick(1);
    miss_valid = 0;
    chk("t1_ar_valid", ar_valid, 1);
    chk("t1_ar_addr", ar_addr, 32'h0000_1200);
    chk("t1_ar_id", ar_id, 5);
    chk("t1_ar_len", ar_len, 1);
    ar_ready = 1;
    tick(1);
    ar_ready = 0;
    chk("t1_outstanding", outstanding, 1);
    ret(0);
    chk("t1_fill_valid", fill_valid, 1);
    chk("t1_fill_data", fill_data, {db, da});
    chk("t1_fill_addr", fill_addr, 32'h0000_1200);
    chk("t1_fill_id", fill_id, 5);
    chk("t1_fill_err", fill_err, 0);
    release_fill();
    chk("t1_free", free, 1);
    chk("t1_free_id", free_id, 5);
    chk("t1_out0", outstanding, 0);
    tick(1);
    chk("t1_free_pulse", free, 0);

    for (int i = 0; i < 8; i++) begin
      miss_valid = 1; miss_addr = 32'h0001_0000 + 32'(i * 64 + 7); miss_id = 10'(10 + i);
      tick(1);
    end
    chk("t2_full", miss_ready, 0);
    chk("t2_head", ar_addr, 32'h0001_0000);
    miss_addr = 32'h0002_0000; miss_id = 10'd18;
    tick(1);
    chk("t2_still_full", miss_ready, 0);
    ar_ready = 1;
    tick(1);
    ar_ready = 0;
    chk("t2_after_pop", miss_ready, 1);
    tick(1);
    miss_valid = 0;
    chk("t2_ninth_in", miss_ready, 0);

    ar_ready = 1;
    for (int g = 0; g < 200 && m_out < 32; g++) begin
      miss_valid = 1; miss_addr = $urandom; miss_id = 10'(20 + g);
      tick(1);
    end
    miss_valid = 0;
    tick(2);
    chk("t3_out32", outstanding, 32);
    chk("t3_ar_blocked", ar_valid, 0);
    ar_ready = 0;

    ret(0);
    for (int i = 0; i < 10; i++) begin
      chk("t4_r_ready", r_ready, 0);
      chk("t4_fill_valid", fill_valid, 1);
      chk("t4_fill_data", fill_data, {db, da});
      chk("t4_fill_id", fill_id, 10);
      tick(1);
    end
    release_fill();
    chk("t4_free", free, 1);
    chk("t4_free_id", free_id, 10);
    chk("t4_out31", outstanding, 31);
    chk("t4_ar_back", ar_valid, 1);
    tick(1);
    chk("t4_free_pulse", free, 0);

    ret(0);
    chk("t5_fill_id", fill_id, 11);
    ar_ready = 1; fill_ready = 1;
    tick(1);
    ar_ready = 0; fill_ready = 0;
    chk("t5_out_same", outstanding, 31);
    chk("t5_free_id", free_id, 11);

    ret(6);
    chk("t6_resp_err", fill_err, 1);
    release_fill();
    chk("t6_free", free, 1);
    chk("t6_free_id", free_id, 12);
    ret(7);
    chk("t6_early_last", fill_err, 1);
    release_fill();
    chk("t6_free_id2", free_id, 13);
`ifdef L3_REFILL_ERR_CNT_EN
    chk("t6_err_cnt", err_cnt, 2);
`endif

    send_beat(da, iss_q.pop_front(), 0, 2'd0);
    chk("t7_no_fill_yet", fill_valid, 0);
    rst = 1;
    tick(1);
    chk("t7_rst_out", outstanding, 0);
    chk("t7_rst_ar", ar_valid, 0);
    chk("t7_rst_r_ready", r_ready, 0);
    chk("t7_rst_miss_ready", miss_ready, 1);
    rst = 0;
    tick(3);
    chk("t7_no_free", free, 0);
    chk("t7_no_fill", fill_valid, 0);
    chk("t7_out0", outstanding, 0);
    chk("t7_q_empty", ar_valid, 0);

    rst = 1;
    tick(2);
    rst = 0;
    b_n = 0; b_i = 0;
    for (int c = 0; c < 4000; c++) begin
      if (r_valid && m_r_acc) begin
        b_i++;
        r_valid = 0;
      end
      if (b_i >= b_n && iss_q.size() > 0) mk_burst(iss_q.pop_front(), $urandom_range(0, 9));
      if (!r_valid && b_i < b_n && $urandom_range(0, 4) != 0) begin
        r_valid = 1; r_data = b_data[b_i]; r_id = b_id[b_i]; r_last = b_last[b_i]; r_resp = b_resp[b_i];
      end
      miss_valid = 1'($urandom_range(0, 1));
      miss_addr = $urandom;
      miss_id = 10'($urandom);
      ar_ready = $urandom_range(0, 3) != 0;
      fill_ready = $urandom_range(0, 2) != 0;
      tick(1);
    end
    miss_valid = 0; ar_ready = 0; r_valid = 0; fill_ready = 0;
    tick(2);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
